sitcp_tcp_stream_buffer: RTL

- Parametrised successor to the fixed 4K-byte TCP echo FIFO beside the SiTCP core.
- Buffers TCP_RX bytes and formats the SiTCP RX window count (TCP_RX_WC) from its own occupancy.
- Drains to TCP_TX under SiTCP TX_FULL back-pressure.
- Adds a selectable incrementing-pattern generator mode, overflow detection and an accepted-byte counter.
- Sits on the SiTCP user clock domain between SiTCP TCP ports and user logic.

---
 rtl/sitcp_tcp_stream_buffer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sitcp_tcp_stream_buffer.sv
// TCP stream buffer for the SiTCP user side: RX FIFO with window count,
// echo drain to TX under TX_FULL, incrementing-pattern burst generator.
module sitcp_tcp_stream_buffer #(
  parameter int          ADDR_W   = 12,
  parameter int          WC_W     = 16,
  parameter logic [7:0]  PAT_SEED = 8'h00
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            TCP_OPEN_ACK,
  input  logic [1:0]      MODE,
  input  logic            PAT_START,
  input  logic [31:0]     PAT_LEN,
  input  logic            TCP_RX_WR,
  input  logic [7:0]      TCP_RX_DATA,
  output logic [WC_W-1:0] TCP_RX_WC,
  input  logic            TCP_TX_FULL,
  output logic            TCP_TX_WR,
  output logic [7:0]      TCP_TX_DATA,
  output logic            OVF,
  output logic            PAT_BUSY,
  output logic [31:0]     RX_BYTE_CNT
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] FULL_CNT = '1;
  localparam logic [ADDR_W-1:0] ONE_CNT = ADDR_W'(1);
  localparam logic [1:0] M_ECHO = 2'b00;
  localparam logic [1:0] M_PAT  = 2'b01;
  localparam logic [1:0] M_HOLD = 2'b10;

  typedef enum logic {PAT_IDLE, PAT_RUN} pat_e;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_last_q, wr_last_d;
  logic [1:0]        mode_q, mode_d;
  pat_e              pat_q, pat_d;
  logic [31:0]       rem_q, rem_d;
  logic [7:0]        val_q, val_d;
  logic              tx_wr_q, tx_wr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       rx_cnt_q, rx_cnt_d;
  logic [WC_W-1:0]   wc_q, wc_d;

  logic full;
  logic rd_ok;
  logic echo_rd;
  logic wr_acc;
  logic pat_fire;
  logic pat_go;

  always_comb begin
    full     = (cnt_q == FULL_CNT);
    // a byte becomes readable one edge after it is written
    rd_ok    = (cnt_q != '0) && !((cnt_q == ONE_CNT) && wr_last_q);
    echo_rd  = TCP_OPEN_ACK && (mode_q == M_ECHO) && rd_ok && !TCP_TX_FULL;
    wr_acc   = TCP_OPEN_ACK && TCP_RX_WR && (!full || echo_rd);
    pat_fire = TCP_OPEN_ACK && (pat_q == PAT_RUN) && !TCP_TX_FULL;
    pat_go   = TCP_OPEN_ACK && (pat_q == PAT_IDLE) && (mode_q == M_PAT)
               && PAT_START && (PAT_LEN != '0);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    wr_last_d = wr_acc;
    mode_d    = (pat_q == PAT_IDLE) ? MODE : mode_q;
    pat_d     = pat_q;
    rem_d     = rem_q;
    val_d     = val_q;
    tx_wr_d   = echo_rd | pat_fire;
    tx_data_d = tx_data_q;
    ovf_d     = ovf_q | (TCP_RX_WR & ~wr_acc);
    rx_cnt_d  = rx_cnt_q + 32'(wr_acc);
    wc_d      = {{(WC_W-ADDR_W){1'b1}}, cnt_q};

    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_CNT;
    if (echo_rd) rd_ptr_d = rd_ptr_q + ONE_CNT;

    unique case ({wr_acc, echo_rd})
      2'b10:   cnt_d = cnt_q + ONE_CNT;
      2'b01:   cnt_d = cnt_q - ONE_CNT;
      default: cnt_d = cnt_q;
    endcase

    if (echo_rd) tx_data_d = mem[rd_ptr_q];
    else if (pat_fire) tx_data_d = val_q;

    unique case (pat_q)
      PAT_IDLE: begin
        if (pat_go) begin
          pat_d = PAT_RUN;
          rem_d = PAT_LEN;
          val_d = PAT_SEED;
        end
      end
      PAT_RUN: begin
        if (pat_fire) begin
          val_d = val_q + 8'd1;
          rem_d = rem_q - 32'd1;
          if (rem_q == 32'd1) pat_d = PAT_IDLE;
        end
      end
      default: pat_d = PAT_IDLE;
    endcase

    // connection closed: drop everything except the byte counter
    if (!TCP_OPEN_ACK) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      wr_last_d = 1'b0;
      ovf_d     = 1'b0;
      pat_d     = PAT_IDLE;
      tx_wr_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      wr_last_q <= 1'b0;
      mode_q    <= M_HOLD;
      pat_q     <= PAT_IDLE;
      rem_q     <= '0;
      val_q     <= '0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
      ovf_q     <= 1'b0;
      rx_cnt_q  <= '0;
      wc_q      <= {{(WC_W-ADDR_W){1'b1}}, {ADDR_W{1'b0}}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      wr_last_q <= wr_last_d;
      mode_q    <= mode_d;
      pat_q     <= pat_d;
      rem_q     <= rem_d;
      val_q     <= val_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
      rx_cnt_q  <= rx_cnt_d;
      wc_q      <= wc_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && wr_acc) mem[wr_ptr_q] <= TCP_RX_DATA;
  end

  assign TCP_RX_WC   = wc_q;
  assign TCP_TX_WR   = tx_wr_q;
  assign TCP_TX_DATA = tx_data_q;
  assign OVF         = ovf_q;
  assign PAT_BUSY    = (pat_q == PAT_RUN);
  assign RX_BYTE_CNT = rx_cnt_q;

endmodule
